// File: rtl/ov7670_capture_win.sv
// OV7670 capture front end: pairs camera bytes into RGB565 pixels, crops to a window,
// skips frames, checks line length and drives a linear frame-buffer write port.
module ov7670_capture_win #(
  parameter int ADDR_W   = 19,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        din,
  input  logic              capture_en,
  input  logic [3:0]        frame_skip,
  input  logic [1:0]        fmt,
  input  logic [X_W-1:0]    win_x0,
  input  logic [Y_W-1:0]    win_y0,
  input  logic [X_W-1:0]    win_w,
  input  logic [Y_W-1:0]    win_h,
  output logic [15:0]       buff_dout,
  output logic              buff_wr,
  output logic [ADDR_W-1:0] buff_addr,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err
);

  typedef enum logic [1:0] {WAIT_VS = 2'd0, ACTIVE = 2'd1, SKIP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, vsync_d, href_q, href_d, phase_q, phase_d;
  logic [7:0]        hi_q, hi_d, frame_cnt_q, frame_cnt_d;
  logic [X_W-1:0]    x_q, x_d, win_x0_q, win_x0_d, win_w_q, win_w_d;
  logic [Y_W-1:0]    y_q, y_d, win_y0_q, win_y0_d, win_h_q, win_h_d;
  logic [3:0]        skip_cnt_q, skip_cnt_d;
  logic [1:0]        fmt_q, fmt_d;
  logic [15:0]       buff_dout_q, buff_dout_d;
  logic              buff_wr_q, buff_wr_d, frame_done_q, frame_done_d, line_err_q, line_err_d;
  logic [ADDR_W-1:0] buff_addr_q, buff_addr_d;

  logic              frame_start_s, frame_end_s, href_fall_s, pix_valid_s, in_win_s, wr_s, active_s;
  logic [15:0]       pix_s;
  logic [X_W:0]      x_ext_s, x_end_s;
  logic [Y_W:0]      y_ext_s, y_end_s;

  // Narrower formats land in the LSBs with the upper bits zero.
  function automatic logic [15:0] fmt_map(input logic [1:0] f, input logic [15:0] p);
    case (f)
      2'd0:    fmt_map = p;
      2'd1:    fmt_map = {4'h0, p[15:12], p[10:7], p[4:1]};
      2'd2:    fmt_map = {8'h00, p[15:13], p[10:8], p[4:3]};
      2'd3:    fmt_map = {p[7:0], p[15:8]};
      default: fmt_map = p;
    endcase
  endfunction

  assign frame_start_s = vsync_q & ~vsync;
  assign frame_end_s   = ~vsync_q & vsync;
  assign href_fall_s   = href_q & ~href;
  assign pix_valid_s   = href & phase_q;
  assign pix_s         = {hi_q, din};

  // State register
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= WAIT_VS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: capture decision is taken only at a vsync falling edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_VS: begin
        if (frame_start_s) begin
          state_d = (capture_en && (skip_cnt_q == 4'd0)) ? ACTIVE : SKIP;
        end else begin
          state_d = WAIT_VS;
        end
      end
      ACTIVE:  state_d = frame_end_s ? WAIT_VS : ACTIVE;
      SKIP:    state_d = frame_end_s ? WAIT_VS : SKIP;
      default: state_d = WAIT_VS;
    endcase
  end

  // FSM outputs
  always_comb begin
    active_s = 1'b0;
    case (state_q)
      WAIT_VS: active_s = 1'b0;
      ACTIVE:  active_s = 1'b1;
      SKIP:    active_s = 1'b0;
      default: active_s = 1'b0;
    endcase
  end

  // Window test at one extra bit so origin + size never wraps
  always_comb begin
    x_ext_s  = {1'b0, x_q};
    y_ext_s  = {1'b0, y_q};
    x_end_s  = {1'b0, win_x0_q} + {1'b0, win_w_q};
    y_end_s  = {1'b0, win_y0_q} + {1'b0, win_h_q};
    in_win_s = (x_ext_s >= {1'b0, win_x0_q}) && (x_ext_s < x_end_s) &&
               (y_ext_s >= {1'b0, win_y0_q}) && (y_ext_s < y_end_s);
    wr_s     = active_s & pix_valid_s & in_win_s;
  end

  // Datapath next-state
  always_comb begin
    vsync_d      = vsync;
    href_d       = href;
    phase_d      = (href && !vsync) ? ~phase_q : 1'b0;
    hi_d         = (href && !phase_q) ? din : hi_q;
    x_d          = href_fall_s ? {X_W{1'b0}} : (pix_valid_s ? x_q + X_W'(1) : x_q);
    buff_wr_d    = wr_s;
    buff_dout_d  = wr_s ? fmt_map(fmt_q, pix_s) : buff_dout_q;
    frame_done_d = active_s & frame_end_s;
    frame_cnt_d  = frame_done_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    if (frame_start_s) begin
      skip_cnt_d  = (skip_cnt_q >= frame_skip) ? 4'd0 : skip_cnt_q + 4'd1;
      y_d         = {Y_W{1'b0}};
      buff_addr_d = {ADDR_W{1'b0}};
      line_err_d  = 1'b0;
      fmt_d       = fmt;
      win_x0_d    = win_x0;
      win_y0_d    = win_y0;
      win_w_d     = win_w;
      win_h_d     = win_h;
    end else begin
      skip_cnt_d  = skip_cnt_q;
      y_d         = href_fall_s ? y_q + Y_W'(1) : y_q;
      buff_addr_d = (buff_wr_q && (buff_addr_q != {ADDR_W{1'b1}})) ? buff_addr_q + ADDR_W'(1)
                                                                   : buff_addr_q;
      // An odd byte count leaves the phase at 1 when href drops
      line_err_d  = (active_s && href_fall_s && ((x_q != X_W'(H_ACTIVE)) || phase_q)) ? 1'b1
                                                                                      : line_err_q;
      fmt_d       = fmt_q;
      win_x0_d    = win_x0_q;
      win_y0_d    = win_y0_q;
      win_w_d     = win_w_q;
      win_h_d     = win_h_q;
    end
  end

  // Datapath registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q <= 1'b0;  href_q <= 1'b0;  phase_q <= 1'b0;  hi_q <= 8'd0;
      x_q <= {X_W{1'b0}};  y_q <= {Y_W{1'b0}};  skip_cnt_q <= 4'd0;  fmt_q <= 2'd0;
      win_x0_q <= {X_W{1'b0}};  win_w_q <= {X_W{1'b0}};
      win_y0_q <= {Y_W{1'b0}};  win_h_q <= {Y_W{1'b0}};
      buff_dout_q <= 16'd0;  buff_wr_q <= 1'b0;  buff_addr_q <= {ADDR_W{1'b0}};
      frame_done_q <= 1'b0;  frame_cnt_q <= 8'd0;  line_err_q <= 1'b0;
    end else begin
      vsync_q <= vsync_d;  href_q <= href_d;  phase_q <= phase_d;  hi_q <= hi_d;
      x_q <= x_d;  y_q <= y_d;  skip_cnt_q <= skip_cnt_d;  fmt_q <= fmt_d;
      win_x0_q <= win_x0_d;  win_w_q <= win_w_d;
      win_y0_q <= win_y0_d;  win_h_q <= win_h_d;
      buff_dout_q <= buff_dout_d;  buff_wr_q <= buff_wr_d;  buff_addr_q <= buff_addr_d;
      frame_done_q <= frame_done_d;  frame_cnt_q <= frame_cnt_d;  line_err_q <= line_err_d;
    end
  end

  assign buff_dout  = buff_dout_q;
  assign buff_wr    = buff_wr_q;
  assign buff_addr  = buff_addr_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign line_err   = line_err_q;

endmodule

// File: tb/tb_ov7670_capture_win.sv
// Directed bench for ov7670_capture_win: format vector table plus frame-level sequences.
module tb_ov7670_capture_win;
  localparam int ADDR_W = 19;

  logic              pclk = 1'b0;
  logic              rst, href, vsync, capture_en;
  logic [7:0]        din;
  logic [3:0]        frame_skip;
  logic [1:0]        fmt;
  logic [9:0]        win_x0, win_w;
  logic [8:0]        win_y0, win_h;
  logic [15:0]       buff_dout;
  logic              buff_wr, frame_done, line_err;
  logic [ADDR_W-1:0] buff_addr;
  logic [7:0]        frame_cnt;

  ov7670_capture_win dut (
    .pclk(pclk), .rst(rst), .href(href), .vsync(vsync), .din(din),
    .capture_en(capture_en), .frame_skip(frame_skip), .fmt(fmt),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .buff_dout(buff_dout), .buff_wr(buff_wr), .buff_addr(buff_addr),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .line_err(line_err)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: expected address restarts at each vsync falling edge seen by the bench
  logic        vs_prev = 1'b0;
  int          fs_cnt = 0, seen_fs = 0, exp_addr = 0;
  int          wr_cnt = 0, fd_cnt = 0, addr_err = 0;
  logic [31:0] last_addr = 32'd0, first_dout = 32'd0, last_dout = 32'd0;

  always @(posedge pclk) begin
    vs_prev <= vsync;
    if (vs_prev && !vsync) fs_cnt <= fs_cnt + 1;
  end

  function automatic int base_addr();
    return (fs_cnt != seen_fs) ? 0 : exp_addr;
  endfunction

  always @(negedge pclk) begin
    seen_fs  <= fs_cnt;
    exp_addr <= (buff_wr === 1'b1) ? base_addr() + 1 : base_addr();
    if (buff_wr === 1'b1) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= 32'(buff_addr);
      last_dout <= 32'(buff_dout);
      if (base_addr() == 0) first_dout <= 32'(buff_dout);
      if (32'(buff_addr) != 32'(base_addr())) addr_err <= addr_err + 1;
    end
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic step(input logic h, input logic v, input logic [7:0] d);
    @(negedge pclk);
    href = h; vsync = v; din = d;
  endtask

  task automatic idle(input int n, input logic v);
    repeat (n) step(1'b0, v, 8'd0);
  endtask

  task automatic frame_begin();
    idle(3, 1'b1);
    idle(2, 1'b0);
  endtask

  task automatic frame_end();
    idle(4, 1'b1);
  endtask

  // Pixel bytes: high = line index, low = column index
  task automatic send_line(input int l, input int npix);
    for (int p = 0; p < npix; p++) begin
      step(1'b1, 1'b0, l[7:0]);
      step(1'b1, 1'b0, p[7:0]);
    end
    idle(3, 1'b0);
  endtask

  task automatic run_frame(input int nl, input int np);
    frame_begin();
    for (int l = 0; l < nl; l++) send_line(l, np);
    frame_end();
  endtask

  task automatic full_window();
    win_x0 = 10'd0; win_y0 = 9'd0; win_w = 10'd1023; win_h = 9'd511;
  endtask

  typedef struct {
    logic [1:0]  f;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];
  int   w0, f0, c0;

  initial begin
    vecs[0] = '{2'd0, 8'hF8, 8'h1F, 16'hF81F};
    vecs[1] = '{2'd1, 8'hF8, 8'h1F, 16'h0F0F};
    vecs[2] = '{2'd2, 8'hF8, 8'h1F, 16'h00E3};
    vecs[3] = '{2'd3, 8'hF8, 8'h1F, 16'h1FF8};
    vecs[4] = '{2'd0, 8'h12, 8'h34, 16'h1234};
    vecs[5] = '{2'd1, 8'hAB, 8'hCD, 16'h0A76};
    vecs[6] = '{2'd2, 8'hAB, 8'hCD, 16'h00AD};
    vecs[7] = '{2'd3, 8'hAB, 8'hCD, 16'hCDAB};
    vecs[8] = '{2'd1, 8'hFF, 8'hFF, 16'h0FFF};

    rst = 1'b1; href = 1'b0; vsync = 1'b0; din = 8'd0;
    capture_en = 1'b1; frame_skip = 4'd0; fmt = 2'd0;
    full_window();
    repeat (3) @(negedge pclk);
    chk("reset_dout", 32'(buff_dout), 32'd0);
    chk("reset_wr_addr", 32'({buff_wr, buff_addr}), 32'd0);
    chk("reset_done_cnt_err", 32'({frame_done, frame_cnt, line_err}), 32'd0);
    rst = 1'b0;

    // Two full 640x4 frames
    for (int f = 0; f < 2; f++) begin
      w0 = wr_cnt;
      run_frame(4, 640);
      chk("full_writes", 32'(wr_cnt - w0), 32'd2560);
      chk("full_last_addr", last_addr, 32'd2559);
    end
    chk("full_frame_done", 32'(fd_cnt), 32'd2);
    chk("full_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("full_line_err", 32'(line_err), 32'd0);
    chk("full_addr_seq", 32'(addr_err), 32'd0);

    // Format table: one pixel per frame, fmt latched at frame start
    for (int i = 0; i < 9; i++) begin
      fmt = vecs[i].f;
      frame_begin();
      step(1'b1, 1'b0, vecs[i].hi);
      step(1'b1, 1'b0, vecs[i].lo);
      step(1'b0, 1'b0, 8'd0);
      chk($sformatf("fmt_wr[%0d]", i), 32'(buff_wr), 32'd1);
      chk($sformatf("fmt_dout[%0d]", i), 32'(buff_dout), 32'(vecs[i].exp));
      idle(3, 1'b0);
      frame_end();
    end
    fmt = 2'd0;

    // Cropping window
    win_x0 = 10'd10; win_y0 = 9'd1; win_w = 10'd4; win_h = 9'd2;
    w0 = wr_cnt; c0 = addr_err;
    run_frame(4, 640);
    chk("win_writes", 32'(wr_cnt - w0), 32'd8);
    chk("win_last_addr", last_addr, 32'd7);
    chk("win_first_pix", first_dout, 32'h010A);
    chk("win_last_pix", last_dout, 32'h020D);
    chk("win_addr_seq", 32'(addr_err - c0), 32'd0);
    full_window();

    // Frame skipping: 1 of every 3 frames
    frame_skip = 4'd2;
    f0 = fd_cnt; c0 = int'(frame_cnt);
    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt;
      run_frame(2, 16);
      chk($sformatf("skip_writes[%0d]", i), 32'(wr_cnt - w0), (i == 0 || i == 3) ? 32'd32 : 32'd0);
    end
    chk("skip_frame_done", 32'(fd_cnt - f0), 32'd2);
    chk("skip_frame_cnt", 32'(frame_cnt), 32'(c0 + 2));
    frame_skip = 4'd0;

    // capture_en: off at frame start blocks the frame; off mid-frame does not
    capture_en = 1'b0;
    w0 = wr_cnt;
    run_frame(1, 16);
    chk("cap_off_writes", 32'(wr_cnt - w0), 32'd0);
    capture_en = 1'b1;
    w0 = wr_cnt;
    frame_begin();
    capture_en = 1'b0;
    send_line(0, 16);
    frame_end();
    chk("cap_mid_writes", 32'(wr_cnt - w0), 32'd16);
    capture_en = 1'b1;

    // Short line sets a sticky line_err cleared at the next frame start
    frame_begin();
    send_line(0, 639);
    chk("lerr_set", 32'(line_err), 32'd1);
    send_line(1, 640);
    chk("lerr_hold", 32'(line_err), 32'd1);
    frame_end();
    chk("lerr_frame_end", 32'(line_err), 32'd1);
    frame_begin();
    chk("lerr_cleared", 32'(line_err), 32'd0);
    send_line(0, 640);
    frame_end();
    chk("lerr_good_line", 32'(line_err), 32'd0);

    // Reset mid-line with vsync low: rest of the frame is ignored
    frame_begin();
    for (int p = 0; p < 10; p++) begin
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, p[7:0]);
    end
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h0A);
    step(1'b1, 1'b0, 8'h00);
    chk("rst_mid_wr_addr", 32'({buff_wr, buff_addr}), 32'd0);
    chk("rst_mid_dout", 32'(buff_dout), 32'd0);
    chk("rst_mid_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    w0 = wr_cnt; f0 = fd_cnt;
    for (int p = 11; p < 100; p++) begin
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, p[7:0]);
    end
    idle(3, 1'b0);
    send_line(1, 640);
    frame_end();
    chk("rst_ignored_writes", 32'(wr_cnt - w0), 32'd0);
    chk("rst_ignored_done", 32'(fd_cnt - f0), 32'd0);
    w0 = wr_cnt;
    run_frame(1, 640);
    chk("rst_next_writes", 32'(wr_cnt - w0), 32'd640);
    chk("rst_next_cnt", 32'(frame_cnt), 32'd1);
    chk("rst_next_lerr", 32'(line_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
